uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, clock cycles per serial bit (legal >= 1); 1 matches the team transmitter's one-bit-per-clk timing.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx  input  1  serial line, idle high, frame = start(0), 8 data bits LSB first, stop(1).
REQ-005 SHALL have port read_en  input  1  consumer acknowledge for the held byte.
REQ-006 SHALL have port data  output  8  last correctly framed byte.
REQ-007 SHALL have port valid  output  1  data holds an unread byte.
REQ-008 SHALL have port frame_err  output  1  sticky: a stop bit was sampled low.
REQ-009 SHALL have port overrun  output  1  sticky: a byte was lost because valid was still set.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (rx_s); all decisions use rx_s, adding 2 cycles of latency.
REQ-012 SHALL implement states IDLE, START, DATA, STOP with a bit-time counter (width clog2(CLKS_PER_BIT)+1) and a 3-bit bit index.
REQ-013 SHALL define HALF = (CLKS_PER_BIT-1)/2 (integer division).
REQ-014 IDLE: on rx_s==0, SHALL go to DATA with counter=0 if HALF==0, else to START with counter=1.
REQ-015 START: SHALL increment counter each cycle; at counter==HALF, rx_s==0 -> DATA with counter=0 and index=0; rx_s==1 -> IDLE (glitch rejected, no flag).
REQ-016 DATA: SHALL increment counter; at counter==CLKS_PER_BIT-1, SHALL store rx_s into shift bit [index], reset counter, and go to STOP after index 7, else increment index.
REQ-017 STOP: at counter==CLKS_PER_BIT-1, SHALL go to IDLE; rx_s==1 -> data loaded from shift register and valid set on the next edge; rx_s==0 -> frame_err set, data and valid unchanged.
REQ-018 SHALL, for CLKS_PER_BIT=1, sample each bit in the cycle after the previous one, with no idle cycle required between stop and next start.
REQ-019 read_en with valid==1 SHALL clear valid, frame_err and overrun on the next edge; read_en with valid==0 SHALL clear only the flags.
REQ-020 SHALL, when a frame completes with valid==1 and read_en==0, overwrite data, keep valid=1, and set overrun.
REQ-021 SHALL, when a frame completes in the same cycle as read_en with valid==1, load new data, keep valid=1, and leave overrun clear.
REQ-022 data SHALL remain stable while valid==1 unless REQ-020 or REQ-021 applies.
REQ-023 A break (rx held low) SHALL produce one frame_err and then stay in IDLE until rx_s returns high before a new start is accepted.

Reset
REQ-024 rst high SHALL immediately force state=IDLE, counter=0, index=0, shift=0, data=0, valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-025 rst asserted mid-frame SHALL discard the partial byte; after release, reception SHALL restart only on a fresh start edge.

Verification
REQ-026 CLKS_PER_BIT=1, drive the 10-bit frame for 0x55 one bit per clk -> valid rises 12 cycles after the start bit is first driven, data=0x55, frame_err=0.
REQ-027 CLKS_PER_BIT=16, frame 0xA3 -> data=0xA3, valid=1; pulse read_en -> valid=0 next cycle.
REQ-028 CLKS_PER_BIT=16, rx low for 3 cycles then high -> returns to IDLE, valid=0, frame_err=0, busy low by cycle 12.
REQ-029 Frame 0x3C with stop bit driven 0 -> frame_err=1, valid=0, data unchanged; read_en -> frame_err=0.
REQ-030 Frames 0x11 then 0x22 with no read_en -> data=0x22, valid=1, overrun=1; repeat with read_en on the completion cycle -> overrun=0.
REQ-031 Assert rst after bit 3 of frame 0xFF, release, then send 0x0F -> only 0x0F is received, and all outputs are 0 during rst.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronised rx, 8N1 framing, single-byte holding register
// with sticky frame-error and overrun flags.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       read_en,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_C = CW'(HALF);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift;
    logic          rx_meta, rx_s;
    logic          armed;
    logic          sample, frame_ok, frame_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        sample    = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!rx_s && armed) begin
                    if (HALF == 0) begin
                        state_n = DATA;
                        cnt_n   = '0;
                    end else begin
                        state_n = START;
                        cnt_n   = CW'(1);
                    end
                end
            end
            START: begin
                if (cnt == HALF_C) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    sample = 1'b1;
                    cnt_n  = '0;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    frame_ok  = rx_s;
                    frame_bad = !rx_s;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // armed blocks a held-low line (break) from being taken as a new start
    // until rx_s has been seen high again in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            if (sample) shift[idx] <= rx_s;

            if (frame_bad)                              armed <= 1'b0;
            else if (frame_ok || (state == IDLE && rx_s)) armed <= 1'b1;

            if (frame_ok) data <= shift;

            if (frame_ok)     valid <= 1'b1;
            else if (read_en) valid <= 1'b0;

            if (frame_bad)    frame_err <= 1'b1;
            else if (read_en) frame_err <= 1'b0;

            if (frame_ok && valid && !read_en) overrun <= 1'b1;
            else if (read_en)                  overrun <= 1'b0;
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule
